// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master among NREQ requesters.
// Define I2C_ARB_RETRY_EN to relaunch NACKed transactions up to MAX_RETRY times.
module i2c_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              nack,
  output logic              timeout,
  output logic [7:0]        rdata,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_ack_err,
  input  logic [7:0]        m_rdata
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  localparam logic [PW-1:0] LAST_REQ   = PW'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t        state_reg;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] win_reg;
  logic [TW-1:0] timer_reg;
  logic [PW-1:0] pick;
  logic [PW-1:0] hi_pick;
  logic [PW-1:0] lo_pick;
  logic          hi_found;
  logic          retry_ok;
  logic [6:0]    addr_arr  [NREQ];
  logic [7:0]    wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[7*gi +: 7];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_pick = PW'(i);
        if (PW'(i) >= ptr_reg) begin
          hi_found = 1'b1;
          hi_pick  = PW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

`ifdef I2C_ARB_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state_reg == IDLE) begin
      retry_cnt <= '0;
    end else if (state_reg == WAIT && m_done && m_ack_err && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_ok = (retry_cnt < RW'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      timer_reg <= '0;
      gnt       <= '0;
      done      <= '0;
      nack      <= 1'b0;
      timeout   <= 1'b0;
      m_start   <= 1'b0;
      rdata     <= '0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_wdata   <= '0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      nack    <= 1'b0;
      timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            win_reg   <= pick;
            gnt       <= NREQ'(1) << pick;
            m_addr    <= addr_arr[pick];
            m_rw      <= req_rw[pick];
            m_wdata   <= wdata_arr[pick];
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (!m_busy) begin
            m_start   <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          timer_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // A completion in the last timer cycle takes priority over the timeout.
          if (m_done) begin
            if (!m_ack_err) begin
              if (m_rw) rdata <= m_rdata;
              done      <= gnt;
              state_reg <= DONE;
            end else if (retry_ok) begin
              state_reg <= LOAD;
            end else begin
              done      <= gnt;
              nack      <= 1'b1;
              state_reg <= DONE;
            end
          end else if (timer_reg == TIMER_LAST) begin
            done      <= gnt;
            timeout   <= 1'b1;
            state_reg <= DONE;
          end else if (timer_reg != TIMER_MAX) begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DONE: begin
          gnt       <= '0;
          ptr_reg   <= (win_reg == LAST_REQ) ? '0 : win_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: cycle-stamped behavioural model checked every cycle,
// plus directed transactions with hand-computed expectations.
module tb_i2c_req_arbiter;
  localparam int NREQ      = 4;
  localparam int TIMEOUT   = 1023;
  localparam int MAX_RETRY = 2;
`ifdef I2C_ARB_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
  localparam int NACK_STARTS = 3;
`else
  localparam int RETRY_LIMIT = 0;
  localparam int NACK_STARTS = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              nack;
  logic              timeout;
  logic [7:0]        rdata;
  logic              m_start;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [7:0]        m_wdata;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic              m_ack_err = 1'b0;
  logic [7:0]        m_rdata = '0;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .nack(nack), .timeout(timeout),
    .rdata(rdata), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
  endtask

  // Master stand-in: mode 0 = ack, 1 = NACK, 2 = silent; m_done lat cycles after m_start.
  int         mst_mode = 0;
  int         mst_lat = 3;
  logic [7:0] mst_rdata = '0;
  int         mst_cnt = -1;
  initial begin
    forever begin
      @(posedge clk); #2;
      m_done    = 1'b0;
      m_ack_err = 1'b0;
      if (rst) begin
        m_busy  = 1'b0;
        mst_cnt = -1;
      end else begin
        if (mst_cnt > 0) begin
          mst_cnt--;
          if (mst_cnt == 0) begin
            m_done    = 1'b1;
            m_ack_err = (mst_mode == 1);
            m_rdata   = mst_rdata;
            m_busy    = 1'b0;
            mst_cnt   = -1;
          end
        end
        if (m_start && mst_mode != 2) begin
          m_busy  = 1'b1;
          mst_cnt = mst_lat;
        end
      end
    end
  end

  // Behavioural model: expectations for the current cycle, derived from cycle stamps.
  logic [NREQ-1:0] e_gnt, e_done;
  logic            e_nack, e_tout, e_start, e_rw;
  logic [7:0]      e_rdata, e_wdata;
  logic [6:0]      e_addr;
  bit free_m, load_m, wait_m, finish_m;
  int win_m, ptr_m, retries_m, start_cyc_m;
  int starts_total = 0;
  int last_start_cyc = 0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic model_reset();
    e_gnt = '0; e_done = '0; e_nack = 1'b0; e_tout = 1'b0; e_start = 1'b0;
    e_rw = 1'b0; e_rdata = '0; e_wdata = '0; e_addr = '0;
    free_m = 1'b1; load_m = 1'b0; wait_m = 1'b0; finish_m = 1'b0;
    win_m = 0; ptr_m = 0; retries_m = 0; start_cyc_m = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_start) begin
        starts_total++;
        last_start_cyc = cyc;
      end
      if (rst) model_reset();
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      chk("nack", 32'(nack), 32'(e_nack));
      chk("timeout", 32'(timeout), 32'(e_tout));
      chk("m_start", 32'(m_start), 32'(e_start));
      chk("rdata", 32'(rdata), 32'(e_rdata));
      chk("m_addr", 32'(m_addr), 32'(e_addr));
      chk("m_rw", 32'(m_rw), 32'(e_rw));
      chk("m_wdata", 32'(m_wdata), 32'(e_wdata));
      if (!rst) begin
        e_start = 1'b0; e_done = '0; e_nack = 1'b0; e_tout = 1'b0;
        if (free_m) begin
          if (req != '0) begin
            win_m = rr_pick(req, ptr_m);
            e_gnt = '0;
            e_gnt[win_m] = 1'b1;
            e_addr  = req_addr[7*win_m +: 7];
            e_rw    = req_rw[win_m];
            e_wdata = req_wdata[8*win_m +: 8];
            free_m = 1'b0; load_m = 1'b1; retries_m = 0;
          end
        end else if (finish_m) begin
          finish_m = 1'b0; free_m = 1'b1; e_gnt = '0;
          ptr_m = (win_m + 1) % NREQ;
        end else if (load_m) begin
          if (!m_busy) begin
            load_m = 1'b0; wait_m = 1'b1; e_start = 1'b1;
            start_cyc_m = cyc + 1;
          end
        end else if (wait_m && cyc > start_cyc_m) begin
          if (m_done) begin
            wait_m = 1'b0;
            if (!m_ack_err) begin
              if (e_rw) e_rdata = m_rdata;
              e_done = e_gnt; finish_m = 1'b1;
            end else if (retries_m < RETRY_LIMIT) begin
              retries_m++; load_m = 1'b1;
            end else begin
              e_done = e_gnt; e_nack = 1'b1; finish_m = 1'b1;
            end
          end else if (cyc == start_cyc_m + TIMEOUT) begin
            wait_m = 1'b0; e_done = e_gnt; e_tout = 1'b1; finish_m = 1'b1;
          end
        end
      end
    end
  end

  int txn_no = 0;
  int txn_starts, txn_lat;

  task automatic wait_done(input int budget, output int idx);
    idx = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done != '0) begin
        for (int b = 0; b < NREQ; b++) if (done[b]) idx = b;
        break;
      end
    end
    if (idx < 0) begin
      n_total++;
      $display("FAIL wait_done no done pulse within %0d cycles", budget);
    end else begin
      $display("txn %0d: requester %0d done nack=%0b timeout=%0b rdata=%02h addr=%02h cyc=%0d",
               txn_no, idx, nack, timeout, rdata, m_addr, cyc);
    end
    txn_no++;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[8*i +: 8] = wd;
    req[i]              = 1'b1;
  endtask

  task automatic one_txn(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input int mode, input int lat, input logic [7:0] rd,
                         input int budget, output int idx);
    int s0;
    @(posedge clk); #1;
    mst_mode = mode; mst_lat = lat; mst_rdata = rd;
    s0 = starts_total;
    set_req(i, a, rw, wd);
    wait_done(budget, idx);
    txn_starts = starts_total - s0;
    txn_lat    = cyc - last_start_cyc;
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    req = '0;
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int idx;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_m_start", 32'(m_start), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    rst = 1'b0;

    // Round-robin with every requester asking.
    @(posedge clk); #1;
    mst_mode = 0; mst_lat = 3;
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(7'h10 + i), 1'b0, 8'(8'h80 + i));
    for (int t = 0; t < 5; t++) begin
      wait_done(200, idx);
      chk("rr_order", 32'(idx), 32'(rr_exp[t]));
      chk("rr_gnt", 32'(gnt), 32'(1) << rr_exp[t]);
      if (idx >= 0) req[idx] = 1'b0;
      @(posedge clk); #1;
      if (t < 4) req = '1;
      else req = '0;
    end

    // Single write.
    one_txn(0, 7'h50, 1'b0, 8'hA5, 0, 40, 8'h00, 200, idx);
    chk("wr_idx", 32'(idx), 32'd0);
    chk("wr_m_addr", 32'(m_addr), 32'h50);
    chk("wr_m_rw", 32'(m_rw), 32'h0);
    chk("wr_m_wdata", 32'(m_wdata), 32'hA5);
    chk("wr_nack", 32'(nack), 32'h0);
    chk("wr_timeout", 32'(timeout), 32'h0);
    chk("wr_starts", 32'(txn_starts), 32'd1);
    chk("wr_latency", 32'(txn_lat), 32'd41);
    release_req();

    // Read.
    one_txn(2, 7'h21, 1'b1, 8'h00, 0, 5, 8'h3C, 200, idx);
    chk("rd_idx", 32'(idx), 32'd2);
    chk("rd_rdata", 32'(rdata), 32'h3C);
    chk("rd_gnt", 32'(gnt), 32'b0100);
    chk("rd_nack", 32'(nack), 32'h0);
    release_req();

    // Slave always NACKs.
    one_txn(1, 7'h2A, 1'b0, 8'h11, 1, 4, 8'h00, 300, idx);
    chk("nk_idx", 32'(idx), 32'd1);
    chk("nk_nack", 32'(nack), 32'h1);
    chk("nk_timeout", 32'(timeout), 32'h0);
    chk("nk_starts", 32'(txn_starts), 32'(NACK_STARTS));
    release_req();

    // Silent master: timeout; rdata from the earlier read must be held.
    one_txn(3, 7'h3F, 1'b1, 8'h00, 2, 0, 8'hEE, 1200, idx);
    chk("to_idx", 32'(idx), 32'd3);
    chk("to_timeout", 32'(timeout), 32'h1);
    chk("to_nack", 32'(nack), 32'h0);
    chk("to_latency", 32'(txn_lat), 32'd1024);
    chk("to_rdata_held", 32'(rdata), 32'h3C);
    release_req();
    chk("to_idle_gnt", 32'(gnt), 32'h0);

    // Reset while waiting on the master.
    mst_mode = 0; mst_lat = 30;
    set_req(1, 7'h33, 1'b0, 8'h5A);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (m_start) break;
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rw_gnt", 32'(gnt), 32'h0);
    chk("rw_done", 32'(done), 32'h0);
    chk("rw_m_start", 32'(m_start), 32'h0);
    chk("rw_m_addr", 32'(m_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_done(100, idx);
    chk("rw_idx", 32'(idx), 32'd1);
    chk("rw_gnt_after", 32'(gnt), 32'b0010);
    chk("rw_nack", 32'(nack), 32'h0);
    chk("rw_timeout", 32'(timeout), 32'h0);
    release_req();
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and transaction sequencer that shares the single-byte I2C master between `NREQ` requesters. It latches the winning requester's address, direction and write byte, and launches one master transaction per grant. It then waits for completion, NACK or timeout, and returns read data and status to the granted requester. It sits between the system-side request ports and the I2C master's command interface.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 1023: max cycles spent in WAIT per attempt (≥2).
- `MAX_RETRY`, 2: NACK relaunches per grant (used only with `I2C_ARB_RETRY_EN`).

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  request per requester; held until its `done` pulse.
- `req_addr`  in  7*NREQ  7-bit slave address; requester i occupies bits [7i+6:7i].
- `req_rw`  in  NREQ  1 = read, 0 = write (standard I2C R/W bit).
- `req_wdata`  in  8*NREQ  write byte; requester i occupies bits [8i+7:8i].
- `gnt`  out  NREQ  one-hot grant, high from LOAD through DONE.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `nack`  out  1  one-cycle pulse, coincident with `done`, on a final NACK.
- `timeout`  out  1  one-cycle pulse, coincident with `done`, on timeout.
- `rdata`  out  8  read byte; valid in the `done` cycle of a successful read, otherwise held.
- `m_start`  out  1  one-cycle launch pulse to the master.
- `m_addr`  out  7  latched address.
- `m_rw`  out  1  latched direction.
- `m_wdata`  out  8  latched write byte.
- `m_busy`  in  1  master is mid-transaction.
- `m_done`  in  1  one-cycle master completion pulse.
- `m_ack_err`  in  1  qualifies `m_done`; 1 = slave NACKed.
- `m_rdata`  in  8  master read byte; valid with `m_done`.

## Operation
- FSM states: IDLE → LOAD → START → WAIT → DONE → IDLE.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit at or after `ptr`, wrapping modulo NREQ.
  - Latch that requester's addr/rw/wdata into `m_addr`/`m_rw`/`m_wdata`, set `gnt`, clear `retry_cnt`, go to LOAD.
- **LOAD:** wait for `m_busy`=0, then go to START.
- **START:** `m_start`=1 for this cycle only. Clear the timer and go to WAIT.
- **WAIT:** timer increments each cycle without `m_done`.
  - On `m_done` with `m_ack_err`=0: capture `m_rdata` if `m_rw`=1, then go to DONE.
  - On `m_done` with `m_ack_err`=1: retry path (see Configuration), else go to DONE with NACK status.
  - If timer = TIMEOUT-1 and there is no `m_done`, go to DONE with timeout status.
- **DONE:**
  - Pulse `done[winner]`, plus `nack` or `timeout` as applicable.
  - Set `ptr` = winner+1 mod NREQ and go to IDLE.
  - `gnt` drops on exit from DONE.
- Timer width is clog2(TIMEOUT+1) and saturates; it never wraps.
- `ptr` advances only in DONE, so a requester that keeps `req` high cannot win twice while others wait.
- `req` deasserted mid-grant is ignored; the transaction still completes and `done` still pulses.
- Other requesters' `req` changes during a grant are ignored until the next IDLE cycle.

## Timing
- Reset values:
  - State IDLE, `ptr`=0, `retry_cnt`=0, timer 0.
  - `gnt`, `done`, `nack`, `timeout` and `m_start` are all 0.
  - `rdata`, `m_addr`, `m_rw` and `m_wdata` are 0.
- Reset mid-transaction clears all outputs immediately (async). The block issues no stop; the master owns bus recovery.
- Request sampled at IDLE edge t: `gnt`/`m_addr` valid from t+1; `m_start` at t+2 when `m_busy` is low.
- `m_done` sampled at edge k gives `done`/`rdata`/status in cycle k+1 and IDLE in cycle k+2. Minimum grant-to-grant turnaround is 3 cycles.
- If `m_start` is in cycle s and the master is silent, the `done`+`timeout` pulse lands in cycle s+TIMEOUT+1.
- If `m_done` arrives in the same cycle as timer = TIMEOUT-1, `m_done` wins.
- `m_done` outside WAIT is ignored.

## Configuration
- Macro `I2C_ARB_RETRY_EN`.
- **Defined:** on NACK with `retry_cnt` < MAX_RETRY, increment `retry_cnt` and go to LOAD.
  - This relaunches with the same latched fields and a fresh timer.
  - `nack` pulses only if the final attempt (MAX_RETRY+1 total) NACKs.
- **Undefined:** the first NACK goes straight to DONE with `nack`. `MAX_RETRY` is unused and `retry_cnt` is not built.

## Test plan
- **Single write:** `req[0]`, addr 7'h50, rw 0, wdata 8'hA5; master `m_done` 40 cycles after start, no error. Expect `m_addr`=7'h50, `m_rw`=0, `m_wdata`=8'hA5, exactly one `m_start`, and a `done[0]` pulse with `nack`=0.
- **Read:** `req[2]`, rw 1, master returns `m_rdata`=8'h3C. Expect `rdata`=8'h3C in the `done[2]` cycle and `gnt`=4'b0100 throughout.
- **Round-robin:** all four `req` held high, each re-asserted after its `done`. Expect grant order 0,1,2,3,0, each `gnt` one-hot.
- **NACK:** master always returns `m_ack_err`=1.
  - Macro off: 1 `m_start`, then `done`+`nack`.
  - Macro on with MAX_RETRY=2: 3 `m_start` pulses, then a single `done`+`nack`.
- **Timeout:** TIMEOUT=1023, master never pulses `m_done`. Expect `done`+`timeout` exactly 1024 cycles after `m_start`, then IDLE.
- **Reset in WAIT:** assert `rst` mid-transaction. Expect `gnt`/`done`/`m_start` to go to 0 immediately. After release, with `req[1]` only, expect `gnt`=4'b0010 and normal completion.
